// File: rtl/fan_start_sequencer.sv
// Fan start-up/shut-down sequencer: kick-start at full duty, slew to the requested
// duty with a minimum-run floor, and retry stalled starts before latching a fault.
module fan_start_sequencer #(
  parameter int unsigned TICK_DIV           = 5_000_000,
  parameter logic [15:0] KICK_DUTY_Q15      = 16'h7FFF,
  parameter int unsigned KICK_TICKS         = 10,
  parameter logic [15:0] SLEW_STEP_Q15      = 16'd512,
  parameter logic [15:0] MIN_RUN_Q15        = 16'd2048,
  parameter int unsigned TACH_TIMEOUT_TICKS = 20,
  parameter int unsigned RETRY_MAX          = 3
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic [15:0] duty_req_q15,
  input  logic        tach_pulse,
  input  logic        tach_chk_en,
  input  logic        fault_clr_pulse,
  output logic [15:0] duty_out_q15,
  output logic        fan_en,
  output logic        fault,
  output logic [2:0]  state_dbg,
  output logic [1:0]  retry_cnt_dbg
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned KW = $clog2(KICK_TICKS + 1);
  localparam int unsigned SW = $clog2(TACH_TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [KW-1:0] kick_cnt;
  logic [SW-1:0] stall_cnt;
  logic [1:0]    retry_cnt;
  logic          tick;

  logic [15:0]   req_eff;
  logic          req_on;
  logic [15:0]   target;
  logic [16:0]   slew_mag;
  logic          slew_up;
  logic          slew_done;
  logic [15:0]   slew_duty;
  logic [SW-1:0] stall_inc;
  logic          stall_expired;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_100mhz) begin
    if (rst || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Negative requests (bit 15 set) are treated as "off".
  always_comb begin
    req_eff = duty_req_q15[15] ? 16'd0 : duty_req_q15;
    req_on  = |req_eff;
    target  = (req_eff > MIN_RUN_Q15) ? req_eff : MIN_RUN_Q15;
  end

  // Magnitude is taken in 17 bits so the distance between two Q1.15 values never wraps.
  always_comb begin
    slew_up = (target >= duty_out_q15);
    if (slew_up) begin
      slew_mag = {1'b0, target} - {1'b0, duty_out_q15};
    end else begin
      slew_mag = {1'b0, duty_out_q15} - {1'b0, target};
    end
    slew_done = (slew_mag <= {1'b0, SLEW_STEP_Q15});
    if (slew_done) begin
      slew_duty = target;
    end else if (slew_up) begin
      slew_duty = duty_out_q15 + SLEW_STEP_Q15;
    end else begin
      slew_duty = duty_out_q15 - SLEW_STEP_Q15;
    end
  end

  // A tach pulse on the tick cycle clears the watchdog, so it cannot expire then.
  always_comb begin
    stall_inc     = stall_cnt + 1'b1;
    stall_expired = tach_chk_en && !tach_pulse && (stall_inc == SW'(TACH_TIMEOUT_TICKS));
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state        <= ST_IDLE;
      duty_out_q15 <= '0;
      fan_en       <= 1'b0;
      fault        <= 1'b0;
      retry_cnt    <= '0;
      kick_cnt     <= '0;
      stall_cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          duty_out_q15 <= '0;
          fan_en       <= 1'b0;
          fault        <= 1'b0;
          retry_cnt    <= '0;
          if (tick && req_on) begin
            state        <= ST_KICK;
            duty_out_q15 <= KICK_DUTY_Q15;
            fan_en       <= 1'b1;
            kick_cnt     <= '0;
            stall_cnt    <= '0;
          end
        end

        ST_KICK, ST_RAMP, ST_RUN: begin
          if (!tach_chk_en || tach_pulse) begin
            stall_cnt <= '0;
          end else if (tick) begin
            stall_cnt <= stall_inc;
          end
          if ((state == ST_RUN) && tach_pulse) begin
            retry_cnt <= '0;
          end
          if (tick) begin
            if (!req_on) begin
              state        <= ST_IDLE;
              duty_out_q15 <= '0;
              fan_en       <= 1'b0;
              retry_cnt    <= '0;
            end else if (stall_expired) begin
              if (retry_cnt < 2'(RETRY_MAX)) begin
                retry_cnt    <= retry_cnt + 1'b1;
                state        <= ST_KICK;
                duty_out_q15 <= KICK_DUTY_Q15;
                fan_en       <= 1'b1;
                kick_cnt     <= '0;
                stall_cnt    <= '0;
              end else begin
                state        <= ST_FAULT;
                duty_out_q15 <= '0;
                fan_en       <= 1'b0;
                fault        <= 1'b1;
              end
            end else if (state == ST_KICK) begin
              kick_cnt <= kick_cnt + 1'b1;
              if (kick_cnt == KW'(KICK_TICKS - 1)) begin
                state <= ST_RAMP;
              end
            end else begin
              duty_out_q15 <= slew_duty;
              if (slew_done) begin
                state <= ST_RUN;
              end
            end
          end
        end

        ST_FAULT: begin
          duty_out_q15 <= '0;
          fan_en       <= 1'b0;
          fault        <= 1'b1;
          if (fault_clr_pulse) begin
            state     <= ST_IDLE;
            fault     <= 1'b0;
            retry_cnt <= '0;
          end
        end

        default: begin
          state        <= ST_IDLE;
          duty_out_q15 <= '0;
          fan_en       <= 1'b0;
          fault        <= 1'b0;
          retry_cnt    <= '0;
        end
      endcase
    end
  end

  assign state_dbg     = state;
  assign retry_cnt_dbg = retry_cnt;

endmodule

// File: tb/tb_fan_start_sequencer.sv
// Directed plus randomized bench for fan_start_sequencer, checked against a
// cycle-level behavioural model of the sequencing rules.
module tb_fan_start_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int KICK_TICKS = 3;
  localparam int TIMEOUT    = 5;
  localparam int RETRY_MAX  = 2;
  localparam int KICK_DUTY  = 'h7FFF;
  localparam int SLEW       = 'h1000;
  localparam int MIN_RUN    = 'h0800;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] duty_req_q15 = '0;
  logic        tach_pulse = 1'b0;
  logic        tach_chk_en = 1'b0;
  logic        fault_clr_pulse = 1'b0;
  logic [15:0] duty_out_q15;
  logic        fan_en;
  logic        fault;
  logic [2:0]  state_dbg;
  logic [1:0]  retry_cnt_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: mode numbers follow the debug encoding IDLE=0..FAULT=4.
  int m_state = 0, m_duty = 0, m_en = 0, m_fault = 0, m_retry = 0;
  int m_kick = 0, m_stall = 0, m_tcnt = 0;
  int tach_mode = 0;
  int tach_odds = 5;
  bit last_tick = 1'b0;

  fan_start_sequencer #(
    .TICK_DIV(TICK_DIV),
    .KICK_DUTY_Q15(16'h7FFF),
    .KICK_TICKS(KICK_TICKS),
    .SLEW_STEP_Q15(16'h1000),
    .MIN_RUN_Q15(16'h0800),
    .TACH_TIMEOUT_TICKS(TIMEOUT),
    .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst(rst),
    .duty_req_q15(duty_req_q15),
    .tach_pulse(tach_pulse),
    .tach_chk_en(tach_chk_en),
    .fault_clr_pulse(fault_clr_pulse),
    .duty_out_q15(duty_out_q15),
    .fan_en(fan_en),
    .fault(fault),
    .state_dbg(state_dbg),
    .retry_cnt_dbg(retry_cnt_dbg)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
      else begin
        tests_failed++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic enter_kick();
    m_state = 1;
    m_duty  = KICK_DUTY;
    m_en    = 1;
    m_kick  = 0;
    m_stall = 0;
  endtask

  task automatic model_step();
    int  req_eff, target, diff, nstall;
    bit  tick, req_on;
    if (rst) begin
      m_state = 0; m_duty = 0; m_en = 0; m_fault = 0; m_retry = 0;
      m_kick = 0; m_stall = 0; m_tcnt = 0;
      return;
    end
    tick    = (m_tcnt == TICK_DIV - 1);
    m_tcnt  = tick ? 0 : m_tcnt + 1;
    req_eff = duty_req_q15[15] ? 0 : int'(duty_req_q15);
    req_on  = (req_eff != 0);
    target  = (req_eff > MIN_RUN) ? req_eff : MIN_RUN;
    case (m_state)
      0: if (tick && req_on) enter_kick();
      1, 2, 3: begin
        nstall  = (!tach_chk_en || tach_pulse) ? 0 : m_stall + (tick ? 1 : 0);
        m_stall = nstall;
        if (m_state == 3 && tach_pulse) m_retry = 0;
        if (tick) begin
          if (!req_on) begin
            m_state = 0; m_duty = 0; m_en = 0; m_retry = 0;
          end else if (nstall == TIMEOUT) begin
            if (m_retry < RETRY_MAX) begin
              m_retry++;
              enter_kick();
            end else begin
              m_state = 4; m_duty = 0; m_en = 0; m_fault = 1;
            end
          end else if (m_state == 1) begin
            m_kick++;
            if (m_kick == KICK_TICKS) m_state = 2;
          end else begin
            diff = target - m_duty;
            if (diff <= SLEW && diff >= -SLEW) begin
              m_duty  = target;
              m_state = 3;
            end else begin
              m_duty = m_duty + ((diff > 0) ? SLEW : -SLEW);
            end
          end
        end
      end
      4: if (fault_clr_pulse) begin
        m_state = 0; m_fault = 0; m_retry = 0;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic check_all();
    check("duty", duty_out_q15, 16'(m_duty));
    check("fan_en", {15'd0, fan_en}, 16'(m_en));
    check("fault", {15'd0, fault}, 16'(m_fault));
    check("state", {13'd0, state_dbg}, 16'(m_state));
    check("retry", {14'd0, retry_cnt_dbg}, 16'(m_retry));
  endtask

  task automatic cycle();
    bit upcoming;
    upcoming = !rst && (m_tcnt == TICK_DIV - 1);
    case (tach_mode)
      0:       tach_pulse = 1'b0;
      1:       tach_pulse = upcoming;
      default: tach_pulse = ($urandom_range(0, tach_odds) == 0);
    endcase
    model_step();
    last_tick = upcoming;
    @(posedge clk_100mhz);
    #1;
    check_all();
  endtask

  task automatic run_ticks(input int n);
    int got;
    got = 0;
    while (got < n) begin
      cycle();
      if (last_tick) got++;
    end
  endtask

  logic [15:0] ramp_exp [3];
  int odds_tab [3];

  initial begin
    ramp_exp = '{16'h6FFF, 16'h5FFF, 16'h4FFF};
    odds_tab = '{3, 30, 1000};

    // 1: reset and idle with no request
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_duty", duty_out_q15, 16'h0000);
    check("rst_state", {13'd0, state_dbg}, 16'd0);
    rst = 1'b0;
    run_ticks(3);
    check("idle_hold", {13'd0, state_dbg}, 16'd0);

    // 2: kick then ramp down to 0x4000 with tach on every tick
    tach_chk_en  = 1'b1;
    tach_mode    = 1;
    duty_req_q15 = 16'h4000;
    run_ticks(1);
    check("kick_state", {13'd0, state_dbg}, 16'd1);
    check("kick_duty", duty_out_q15, 16'h7FFF);
    check("kick_en", {15'd0, fan_en}, 16'd1);
    run_ticks(2);
    check("kick_len", {13'd0, state_dbg}, 16'd1);
    run_ticks(1);
    check("ramp_entry", {13'd0, state_dbg}, 16'd2);
    for (int i = 0; i < 3; i++) begin
      run_ticks(1);
      check("ramp_duty", duty_out_q15, ramp_exp[i]);
      check("ramp_state", {13'd0, state_dbg}, 16'd2);
    end
    run_ticks(1);
    check("run_state", {13'd0, state_dbg}, 16'd3);
    check("run_duty", duty_out_q15, 16'h4000);

    // 3: floor at minimum run duty, negative request means off
    duty_req_q15 = 16'h0000;
    run_ticks(1);
    check("drop_idle", {13'd0, state_dbg}, 16'd0);
    duty_req_q15 = 16'h0100;
    run_ticks(20);
    check("floor_duty", duty_out_q15, 16'h0800);
    check("floor_state", {13'd0, state_dbg}, 16'd3);
    duty_req_q15 = 16'h8001;
    run_ticks(1);
    check("neg_state", {13'd0, state_dbg}, 16'd0);
    check("neg_duty", duty_out_q15, 16'h0000);
    check("neg_en", {15'd0, fan_en}, 16'd0);

    // 4: stall retries then fault, then clear
    tach_mode    = 0;
    duty_req_q15 = 16'h4000;
    run_ticks(1);
    run_ticks(5);
    check("retry1", {14'd0, retry_cnt_dbg}, 16'd1);
    check("retry1_state", {13'd0, state_dbg}, 16'd1);
    run_ticks(5);
    check("retry2", {14'd0, retry_cnt_dbg}, 16'd2);
    run_ticks(5);
    check("fault_state", {13'd0, state_dbg}, 16'd4);
    check("fault_flag", {15'd0, fault}, 16'd1);
    check("fault_duty", duty_out_q15, 16'h0000);
    run_ticks(3);
    check("fault_hold", {13'd0, state_dbg}, 16'd4);
    fault_clr_pulse = 1'b1;
    cycle();
    fault_clr_pulse = 1'b0;
    check("clr_state", {13'd0, state_dbg}, 16'd0);
    check("clr_fault", {15'd0, fault}, 16'd0);
    run_ticks(1);
    check("restart", {13'd0, state_dbg}, 16'd1);

    // 5: request drop wins over a coincident stall timeout; tach on tick clears watchdog
    run_ticks(4);
    duty_req_q15 = 16'h0000;
    run_ticks(1);
    check("drop_vs_stall", {13'd0, state_dbg}, 16'd0);
    check("drop_no_retry", {14'd0, retry_cnt_dbg}, 16'd0);
    duty_req_q15 = 16'h4000;
    tach_mode    = 1;
    run_ticks(12);
    check("tach_tick_state", {13'd0, state_dbg}, 16'd3);
    check("tach_tick_retry", {14'd0, retry_cnt_dbg}, 16'd0);

    // 6: reset mid-ramp
    duty_req_q15 = 16'h0000;
    run_ticks(1);
    duty_req_q15 = 16'h4000;
    run_ticks(5);
    check("pre_rst_ramp", {13'd0, state_dbg}, 16'd2);
    check("pre_rst_duty", duty_out_q15, 16'h6FFF);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_state", {13'd0, state_dbg}, 16'd0);
    check("mid_rst_duty", duty_out_q15, 16'h0000);
    check("mid_rst_en", {15'd0, fan_en}, 16'd0);
    run_ticks(2);

    // Randomized traffic against the model
    tach_mode = 2;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) tach_odds = odds_tab[$urandom_range(0, 2)];
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0:       duty_req_q15 = 16'h0000;
          1:       duty_req_q15 = {1'b1, 15'($urandom)};
          2:       duty_req_q15 = 16'($urandom_range(1, 'h0FFF));
          default: duty_req_q15 = 16'($urandom_range(1, 'h7FFF));
        endcase
      end
      if ($urandom_range(0, 199) == 0) tach_chk_en = ~tach_chk_en;
      fault_clr_pulse = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 1'b0;
    fault_clr_pulse = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fan_start_sequencer.md
Name: fan_start_sequencer

Overview:
Sits between the temperature/PIR/manual duty arbiter and the fan PWM generator, and sequences fan start-up and shut-down. On a start request it kick-starts the fan at full duty, then slew-limits down or up to the requested duty with a minimum-run floor. While running it monitors the tachometer and retries the start, up to a bounded count, before latching a fault.

Parameters:
- TICK_DIV, 5_000_000: clk_100mhz cycles per sequencer tick (20 Hz).
- KICK_DUTY_Q15, 16'h7FFF: Q1.15 duty applied during kick-start.
- KICK_TICKS, 10: number of ticks spent in KICK.
- SLEW_STEP_Q15, 16'd512: maximum duty change per tick in RAMP/RUN.
- MIN_RUN_Q15, 16'd2048: duty floor while the fan is running.
- TACH_TIMEOUT_TICKS, 20: ticks without a tach pulse that count as a stall.
- RETRY_MAX, 3: kick retries allowed before FAULT.

Ports:
- clk_100mhz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- duty_req_q15  in  16  requested duty, Q1.15 (arbiter output).
- tach_pulse  in  1  one-cycle pulse per tach edge, already synchronised and debounced.
- tach_chk_en  in  1  enables the stall watchdog.
- fault_clr_pulse  in  1  one-cycle fault acknowledge.
- duty_out_q15  out  16  sequenced duty to the PWM mapper, Q1.15, registered.
- fan_en  out  1  fan driver enable, registered.
- fault  out  1  latched stall fault.
- state_dbg  out  3  IDLE=0, KICK=1, RAMP=2, RUN=3, FAULT=4.
- retry_cnt_dbg  out  2  retries used.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset takes effect mid-operation on the next edge.
- Tick generator:
  - Counter runs 0..TICK_DIV-1.
  - tick is high for one cycle when counter==TICK_DIV-1.
- Request qualification:
  - req_eff = 0 if duty_req_q15[15] is set, else duty_req_q15.
  - req_on = (req_eff != 0).
  - target = max(req_eff, MIN_RUN_Q15).
- Evaluation rules:
  - All transitions are evaluated on tick cycles only, except fault_clr_pulse and rst.
  - Outputs are registered and reflect a new state one cycle after the tick.
- IDLE:
  - duty_out=0, fan_en=0, retry_cnt=0.
  - Tick with req_on → KICK; kick_cnt=0, stall_cnt=0.
- KICK:
  - duty_out=KICK_DUTY_Q15, fan_en=1.
  - Each tick increments kick_cnt.
  - Tick with kick_cnt==KICK_TICKS-1 → RAMP.
- RAMP:
  - Each tick: if |target−duty_out| ≤ SLEW_STEP_Q15, set duty_out=target and go to RUN.
  - Otherwise step duty_out by SLEW_STEP_Q15 toward target.
  - Compute in 17-bit signed; no wrap.
- RUN:
  - Same per-tick slew toward target; state stays RUN.
  - tach_pulse clears retry_cnt.
- Leaving KICK/RAMP/RUN on request removal:
  - Tick with !req_on → IDLE; duty_out=0 and fan_en=0 immediately (no ramp-down).
  - This has priority over the stall timeout on the same tick.
- Stall watchdog (KICK/RAMP/RUN, tach_chk_en=1):
  - stall_cnt increments on each tick and clears on any tach_pulse cycle.
  - If tach_pulse and tick coincide, the clear wins.
  - When stall_cnt reaches TACH_TIMEOUT_TICKS on a tick:
    - retry_cnt<RETRY_MAX → retry_cnt++, go to KICK, kick_cnt=0, stall_cnt=0.
    - Otherwise → FAULT.
  - With tach_chk_en=0, stall_cnt is held at 0.
- FAULT:
  - duty_out=0, fan_en=0, fault=1; req is ignored.
  - fault_clr_pulse on any cycle → IDLE, fault=0, retry_cnt=0.
  - fault_clr_pulse outside FAULT has no effect.
- retry_cnt saturates at RETRY_MAX.

Test Plan:
Bench parameters: TICK_DIV=4, KICK_TICKS=3, SLEW=0x1000, MIN_RUN=0x0800, TIMEOUT=5, RETRY_MAX=2.
1. Reset → all outputs 0 and state 0. Release with req=0 → state stays IDLE indefinitely.
2. req=0x4000, tach every tick → KICK with duty 0x7FFF for 3 ticks, then RAMP 0x6FFF, 0x5FFF, 0x4FFF, then 0x4000 in RUN; fan_en=1 throughout.
3. req=0x0100 → after kick, duty settles at floor 0x0800. Req then 0x8001 → treated as 0; next tick gives IDLE with duty 0 and fan_en 0.
4. req=0x4000, tach_chk_en=1, no tach → retries at 5-tick intervals (retry_cnt 1, then 2), then FAULT with fault=1, duty 0. fault_clr_pulse → IDLE next cycle; a held req restarts KICK on the following tick.
5. Stall timeout tick coincident with req drop → IDLE, no retry. tach_pulse coincident with tick → stall_cnt=0.
6. rst asserted mid-RAMP → next cycle all outputs 0, state IDLE, counters 0.
